pack_stream_arbiter: RTL and testbench
======================================

// Module: pack_stream_arbiter
// PURPOSE
// - Shares one data_packer instance between NUM_SRC AXI-Stream byte sources.
// - Arbitrates round-robin at packet granularity; a grant is held until the granted source's tlast beat.
// - Drives the packer's k input from a per-source config, held stable for the whole packet.
// - Forces a packet boundary when a packet exceeds MAX_BEATS beats, and flags the event.
// PARAMETERS
// - DATA_WIDTH  8     width of tdata on every stream
// - NUM_SRC     4     number of requesting sources (2..16)
// - SRC_W       $clog2(NUM_SRC)   width of the source index
// - MAX_BEATS   512   maximum beats per packet before a forced tlast (matches packer buffer)
// - CNT_W       $clog2(MAX_BEATS+1)   width of the beat counter
// PORTS
// - clk            in   1                   clock
// - reset          in   1                   reset, asynchronous, active-high
// - cfg_k          in   NUM_SRC*2           per-source packer k; source i uses bits [2i+1:2i]
// - s_axis_tdata   in   NUM_SRC*DATA_WIDTH  source data, source i uses slice i
// - s_axis_tvalid  in   NUM_SRC             per-source valid
// - s_axis_tready  out  NUM_SRC             per-source ready
// - s_axis_tlast   in   NUM_SRC             per-source last
// - m_axis_tdata   out  DATA_WIDTH          to packer s_axis_tdata
// - m_axis_tvalid  out  1                   to packer
// - m_axis_tready  in   1                   from packer
// - m_axis_tlast   out  1                   to packer (source tlast OR forced)
// - m_k            out  2                   to packer k; registered at grant
// - m_src          out  SRC_W               index of the granted source
// - busy           out  1                   high while a grant is held
// - overrun_err    out  NUM_SRC             sticky per-source forced-tlast flag; write-1 clear via err_clr
// - err_clr        in   NUM_SRC             clears the matching overrun_err bits
// BEHAVIOUR
// - Reset values: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_k=0, m_src=0, busy=0, overrun_err=0.
// - Reset values, internal: rr pointer=0, beat count=0, state=IDLE.
// - FSM IDLE: if any s_axis_tvalid, pick the first requester at or after the rr pointer (wrapping).
//   - Register g, m_src=g, m_k=cfg_k[g] and beat count=0; go to XFER next cycle (1-cycle arbitration bubble).
// - FSM XFER: combinational pass-through from the granted source only:
//   - m_axis_tvalid = s_axis_tvalid[g]; m_axis_tdata = slice g; s_axis_tready[g] = m_axis_tready.
//   - All other s_axis_tready = 0.
// - A beat is accepted when m_axis_tvalid & m_axis_tready. Each accepted beat increments the beat count.
// - m_axis_tlast = s_axis_tlast[g] | (count == MAX_BEATS-1).
// - On an accepted beat with m_axis_tlast=1:
//   - Go to IDLE and set rr pointer = g+1 (mod NUM_SRC).
//   - If the tlast was forced (source tlast=0), set overrun_err[g].
//   - The source's remaining beats then form a new packet and re-arbitrate.
// - busy = (state==XFER). In IDLE, m_axis_tvalid=0 and m_axis_tlast=0.
// - cfg_k changes during XFER are ignored until the next grant.
// - k values are forwarded unchanged.
// - Boundary conditions:
//   - The valid of a granted source may drop mid-packet: the grant is held with no timeout.
//   - Backpressure (m_axis_tready=0) holds all outputs stable.
//   - A single-beat packet (tlast on beat 0) is legal: XFER lasts exactly one accepted beat.
//   - If err_clr and a set event hit the same bit in the same cycle, the set wins.
//   - Requests that appear during XFER wait. No source is granted twice while another is pending.
//   - Asynchronous reset mid-packet returns to IDLE immediately; the partial packet is dropped.
// - Latency: grant registered 1 cycle after request; data path 0 cycles (combinational) during XFER.
// STRUCTURE
// - pack_pkg:
//   - typedef logic [1:0] pack_k_t.
//   - typedef enum logic {IDLE, XFER} pack_arb_state_t.
//   - localparam PACK_MAX_BEATS = 512.
// - Sub-module rr_arbiter #(N): req[N], ptr[SRC_W] -> gnt_valid, gnt_idx (purely combinational).
// - Top level holds the FSM, the grant/k registers, the beat counter, the rr pointer and the error flags.
// TESTING
// - Only src2 valid, 3-beat packet, cfg_k[2]=2 -> m_src=2 and m_k=2 one cycle later; 3 beats out; tlast on beat 3; busy drops.
// - All 4 sources valid continuously, 2-beat packets -> grant order 0,1,2,3,0.
//   - One IDLE cycle between packets.
//   - s_axis_tready is never high for an ungranted source.
// - src1 sends 514 beats with no tlast, MAX_BEATS=512 -> m_axis_tlast on beat 512 and overrun_err[1]=1.
//   - Then a new grant (src1 re-wins if alone); beats 513-514 form a second packet.
// - Granted src0 mid-packet with m_axis_tready toggling 1010 and cfg_k changed 1->3:
//   - No beat lost or duplicated; m_k stays 1 until the next grant.
// - Assert reset during beat 2 of 4 -> next cycle all outputs are at reset values.
//   - After release, arbitration restarts at src0.
// - err_clr[1]=1 in the same cycle as the forced-tlast beat of src1 -> overrun_err[1] stays 1.
//   - err_clr[1]=1 the following cycle -> the bit clears.

Source files
------------

// File: rtl/pack_pkg.sv
// Shared types and constants for the packer stream arbiter.
package pack_pkg;
  typedef logic [1:0] pack_k_t;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} pack_arb_state_t;
  localparam int PACK_MAX_BEATS = 512;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter
  import pack_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      // ptr and offset are both below N, so one subtraction wraps the sum.
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/pack_stream_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC byte streams onto one data_packer,
// with per-grant k selection and a forced boundary after MAX_BEATS beats.
module pack_stream_arbiter
  import pack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int SRC_W      = $clog2(NUM_SRC),
  parameter int MAX_BEATS  = PACK_MAX_BEATS,
  parameter int CNT_W      = $clog2(MAX_BEATS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*2-1:0]          cfg_k,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [1:0]                    m_k,
  output logic [SRC_W-1:0]              m_src,
  output logic                          busy,
  output logic [NUM_SRC-1:0]            overrun_err,
  input  logic [NUM_SRC-1:0]            err_clr
);

  pack_arb_state_t state_q, state_d;
  logic [SRC_W-1:0] gnt_q, gnt_d, ptr_q, ptr_d;
  pack_k_t          k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0] err_q, err_d;
  logic             arb_valid;
  logic [SRC_W-1:0] arb_idx;
  logic             sel_valid, sel_last, at_limit;

  rr_arbiter #(.N(NUM_SRC), .IW(SRC_W)) u_rr (
    .req_i       (s_axis_tvalid),
    .ptr_i       (ptr_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // Handshake: a beat moves on a cycle where valid and ready are both high;
  // valid never waits on ready, and the granted source sees the packer's ready.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    k_d           = k_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    err_d         = err_q & ~err_clr;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    sel_valid     = s_axis_tvalid[gnt_q];
    sel_last      = s_axis_tlast[gnt_q];
    at_limit      = (cnt_q == CNT_W'(MAX_BEATS - 1));
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          k_d     = cfg_k[2*arb_idx +: 2];
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        m_axis_tvalid        = sel_valid;
        m_axis_tdata         = s_axis_tdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast         = sel_last | at_limit;
        s_axis_tready[gnt_q] = m_axis_tready;
        if (sel_valid && m_axis_tready) begin
          cnt_d = cnt_q + 1'b1;
          if (m_axis_tlast) begin
            state_d = IDLE;
            ptr_d   = (gnt_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_q + 1'b1;
            // A set in the same cycle as a clear must win.
            if (!sel_last) err_d[gnt_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      k_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign m_k         = k_q;
  assign m_src       = gnt_q;
  assign busy        = (state_q == XFER);
  assign overrun_err = err_q;

endmodule

// File: tb/tb_pack_stream_arbiter.sv
// Randomized bench for pack_stream_arbiter against a packet-level round-robin model.
module tb_pack_stream_arbiter;
  import pack_pkg::*;

  localparam int DW   = 8;
  localparam int NS   = 4;
  localparam int SW   = 2;
  localparam int MAXB = 512;
  localparam int EW   = SW + 2 + 1 + DW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [NS*2-1:0]  cfg_k;
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]       m_k;
  logic [SW-1:0]    m_src;
  logic             busy;
  logic [NS-1:0]    overrun_err, err_clr;

  always #5 clk = ~clk;

  pack_stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset(reset), .cfg_k(cfg_k),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_k(m_k), .m_src(m_src), .busy(busy),
    .overrun_err(overrun_err), .err_clr(err_clr)
  );

  // ---------------- bench state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW:0]   src_q [NS][$];   // {last, data} still to be driven per source
  logic [DW:0]   mdl_q [NS][$];   // same beats, consumed by the model
  logic [EW-1:0] exp_q [$];       // {src, k, last, data} expected on the packer side
  logic [NS-1:0] live_err, set_now, acc, clr_val;
  int  model_ptr;
  int  tready_mode;
  logic tready_phase;
  bit  allow_drop, expect_idle, clr_on_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic add_pkt(input int s, input int len, input bit with_last);
    logic [DW:0] e;
    logic l;
    for (int b = 0; b < len; b++) begin
      l = with_last && (b == len - 1);
      e = {l, DW'($urandom_range(0, 255))};
      src_q[s].push_back(e);
      mdl_q[s].push_back(e);
    end
  endtask

  // Packets go out round-robin among sources with data; a packet ends on the
  // source's last beat or on its MAX_BEATS-th beat, whichever comes first.
  task automatic model_run();
    int s, n;
    logic [DW:0] b;
    logic forced;
    logic [1:0] k;
    while (1) begin
      s = -1;
      for (int i = 0; i < NS; i++)
        if (s < 0 && mdl_q[(model_ptr + i) % NS].size() > 0) s = (model_ptr + i) % NS;
      if (s < 0) break;
      k = cfg_k[2*s +: 2];
      n = 0;
      do begin
        b = mdl_q[s].pop_front();
        n++;
        forced = !b[DW] && (n == MAXB);
        exp_q.push_back({SW'(s), k, b[DW] | forced, b[DW-1:0]});
      end while (!b[DW] && !forced && mdl_q[s].size() > 0);
      model_ptr = (s + 1) % NS;
    end
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush_all();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    live_err    = '0;
    set_now     = '0;
    model_ptr   = 0;
    expect_idle = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    logic v;
    for (int i = 0; i < NS; i++) begin
      v = src_q[i].size() > 0;
      // Only a currently granted source may drop valid mid-packet.
      if (allow_drop && busy && m_src == SW'(i) && $urandom_range(0, 3) == 0) v = 1'b0;
      s_axis_tvalid[i] = v;
      s_axis_tdata[i*DW +: DW] = src_q[i].size() > 0 ? src_q[i][0][DW-1:0] : '0;
      s_axis_tlast[i]  = src_q[i].size() > 0 ? src_q[i][0][DW] : 1'b0;
    end
    case (tready_mode)
      0: m_axis_tready = 1'b1;
      1: begin m_axis_tready = tready_phase; tready_phase = ~tready_phase; end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    err_clr = clr_val;
  endtask

  // ---------------- scoreboard / monitor (negedge) ----------------
  task automatic monitor();
    logic [NS-1:0] allowed;
    logic [EW-1:0] e;
    int cur;
    acc = '0;
    if (reset) return;
    cur = exp_q.size() > 0 ? int'(exp_q[0][EW-1 -: SW]) : -1;
    if (expect_idle) begin
      check("idle_gap", busy, 0);
      expect_idle = 1'b0;
    end
    if (!busy) check("idle_quiet", {m_axis_tvalid, m_axis_tlast}, 0);
    allowed = '0;
    if (cur >= 0) allowed[cur] = 1'b1;
    check("tready_mask", s_axis_tready & ~allowed, 0);
    if (busy && cur >= 0) check("tready_pass", s_axis_tready[cur], m_axis_tready);
    check("overrun", overrun_err, live_err);
    acc = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      if (cur < 0) check("extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("beat", {m_src, m_k, m_axis_tlast, m_axis_tdata}, e);
        if (e[DW]) expect_idle = 1'b1;
        if (e[DW] && src_q[cur].size() > 0 && !src_q[cur][0][DW]) begin
          set_now[cur] = 1'b1;
          if (clr_on_force) err_clr[cur] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    live_err = reset ? '0 : ((live_err & ~err_clr) | set_now);
    set_now  = '0;
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || src_pending()) && c < budget) begin
      cycle();
      c++;
    end
    if (c >= budget) begin
      check("drain_timeout", 1, 0);
      flush_all();
    end
    cycle();
    cycle();
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_tready"}, s_axis_tready, 0);
    check({pfx, "_tvalid"}, m_axis_tvalid, 0);
    check({pfx, "_tlast"}, m_axis_tlast, 0);
    check({pfx, "_k"}, m_k, 0);
    check({pfx, "_src"}, m_src, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_err"}, overrun_err, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    flush_all();
    clr_val = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    err_clr       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    reset = 1'b1; cfg_k = '0; m_axis_tready = 1'b0;
    tready_mode = 0; tready_phase = 1'b1; allow_drop = 1'b0;
    clr_on_force = 1'b0; clr_val = '0; acc = '0;
    apply_reset();

    // Lone src2, 3-beat packet, k=2: grant one cycle after request.
    cfg_k = 8'b0010_0000;
    add_pkt(2, 3, 1);
    model_run();
    cycle();
    check("a_busy", busy, 1);
    check("a_src", m_src, 2);
    check("a_k", m_k, 2);
    run_drain(50);

    // All sources busy with 2-beat packets: order 0,1,2,3,0,...
    apply_reset();
    cfg_k = 8'($urandom);
    for (int s = 0; s < NS; s++) begin
      add_pkt(s, 2, 1);
      add_pkt(s, 2, 1);
    end
    model_run();
    run_drain(200);

    // 514 unterminated beats from src1: forced tlast at 512, clear colliding with set.
    apply_reset();
    cfg_k = 8'($urandom);
    add_pkt(1, 513, 0);
    add_pkt(1, 1, 1);
    model_run();
    clr_on_force = 1'b1;
    run_drain(1200);
    clr_on_force = 1'b0;
    check("err_after_force", overrun_err, 4'b0010);
    clr_val = 4'b0010;
    cycle();
    clr_val = '0;
    check("err_cleared", overrun_err, 0);

    // Toggling backpressure with cfg_k changed mid-packet.
    apply_reset();
    cfg_k = 8'h01;
    tready_mode = 1;
    add_pkt(0, 6, 1);
    model_run();
    cycle();
    cycle();
    cfg_k = 8'h03;
    run_drain(100);
    add_pkt(0, 3, 1);
    model_run();
    run_drain(100);
    tready_mode = 0;

    // Async reset during beat 2 of 4, then arbitration restarts at src0.
    apply_reset();
    cfg_k = 8'he4;
    add_pkt(1, 2, 1);
    model_run();
    run_drain(50);
    add_pkt(0, 4, 1);
    model_run();
    g = 0;
    while (src_q[0].size() > 3 && g < 20) begin
      cycle();
      g++;
    end
    check("rst_mid_reached", src_q[0].size(), 3);
    drive();
    @(negedge clk);
    #1 reset = 1'b1;
    flush_all();
    @(posedge clk);
    #1;
    check_reset_vals("rst_mid");
    reset = 1'b0;
    add_pkt(3, 2, 1);
    add_pkt(0, 2, 1);
    model_run();
    cycle();
    check("rst_restart_src", m_src, 0);
    run_drain(50);

    // Randomized traffic with backpressure and granted-valid drops.
    apply_reset();
    tready_mode = 2;
    allow_drop  = 1'b1;
    repeat (4) begin
      cfg_k = 8'($urandom);
      for (int s = 0; s < NS; s++)
        repeat ($urandom_range(0, 3)) add_pkt(s, $urandom_range(1, 8), 1);
      model_run();
      run_drain(3000);
    end
    allow_drop = 1'b0;
    check("final_err", overrun_err, 0);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
